// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and image framing constants for the program loader
package loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } load_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 4;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop synchronizer, start-bit glitch rejection
// and a one-cycle byte_valid pulse in the middle of the stop bit.
module uart_rx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state, state_n;
    logic             rx_meta, rx_sync;
    logic             armed, armed_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             valid_n, ferr_n;
    logic [7:0]       data_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta    <= 1'b0;
            rx_sync    <= 1'b0;
            state      <= RX_IDLE;
            armed      <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            state      <= state_n;
            armed      <= armed_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_valid <= valid_n;
            byte_data  <= data_n;
            frame_err  <= ferr_n;
        end
    end

    // armed records that the line has been seen high, so a line held low
    // across reset release is not mistaken for a start edge.
    always_comb begin
        state_n   = state;
        armed_n   = armed;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        valid_n   = 1'b0;
        data_n    = byte_data;
        ferr_n    = frame_err;
        case (state)
            RX_IDLE: begin
                cnt_n   = '0;
                armed_n = armed | rx_sync;
                if (armed && !rx_sync) begin
                    state_n = RX_START;
                    armed_n = 1'b0;
                    cnt_n   = CNT_W'(1);
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_sync, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    valid_n = 1'b1;
                    data_n  = shreg;
                    ferr_n  = !rx_sync;
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - UART program loader writing big-endian words into instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module inst_loader
    import loader_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int MAX_WORDS   = 200,
    parameter int ADDR_W      = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              rx,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef LOADER_CHECKSUM_EN
    localparam load_state_t ST_TAIL = ST_CSUM;
`else
    localparam load_state_t ST_TAIL = ST_DONE;
`endif

    logic        byte_valid, frame_err;
    logic [7:0]  byte_data;

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    load_state_t       state, state_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [ADDR_W:0]   word_idx, word_idx_n;
    logic [ADDR_W:0]   word_cnt, word_cnt_n;
    logic [23:0]       shreg, shreg_n;
    logic [31:0]       shifted;
    logic              last_word, last_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       wdata_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        acc, acc_n;
`endif

    assign shifted = {shreg, byte_data};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_HDR;
            byte_cnt  <= '0;
            word_idx  <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
            last_word <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            state     <= state_n;
            byte_cnt  <= byte_cnt_n;
            word_idx  <= word_idx_n;
            word_cnt  <= word_cnt_n;
            shreg     <= shreg_n;
            last_word <= last_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
`ifdef LOADER_CHECKSUM_EN
            acc       <= acc_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        word_idx_n = word_idx;
        word_cnt_n = word_cnt;
        shreg_n    = shreg;
        last_n     = 1'b0;
        we_n       = 1'b0;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
`ifdef LOADER_CHECKSUM_EN
        acc_n      = acc;
`endif
        if (restart) begin
            state_n    = ST_HDR;
            byte_cnt_n = '0;
            word_idx_n = '0;
`ifdef LOADER_CHECKSUM_EN
            acc_n      = '0;
`endif
        end else begin
            case (state)
                ST_HDR: begin
                    if (byte_valid) begin
                        if (frame_err) begin
                            state_n = ST_ERR;
                        end else begin
                            shreg_n    = shifted[23:0];
                            byte_cnt_n = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            acc_n      = acc ^ byte_data;
`endif
                            if (byte_cnt == 2'(HDR_BYTES - 1)) begin
                                byte_cnt_n = '0;
                                word_idx_n = '0;
                                word_cnt_n = shifted[ADDR_W:0];
                                if (shifted > 32'(MAX_WORDS)) state_n = ST_ERR;
                                else if (shifted == 32'd0)    state_n = ST_TAIL;
                                else                          state_n = ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    // Hold one extra cycle after the last word so done trails the final write.
                    if (last_word) begin
                        state_n = ST_TAIL;
                    end else if (byte_valid) begin
                        if (frame_err) begin
                            state_n = ST_ERR;
                        end else begin
                            shreg_n    = shifted[23:0];
                            byte_cnt_n = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            acc_n      = acc ^ byte_data;
`endif
                            if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                                byte_cnt_n = '0;
                                we_n       = 1'b1;
                                addr_n     = word_idx[ADDR_W-1:0];
                                wdata_n    = shifted;
                                word_idx_n = word_idx + 1'b1;
                                last_n     = ((word_idx + 1'b1) == word_cnt);
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (byte_valid) begin
                        if (frame_err)             state_n = ST_ERR;
                        else if (byte_data == acc) state_n = ST_DONE;
                        else                       state_n = ST_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader (CLK_PER_BIT=8, MAX_WORDS=200)
module tb_inst_loader;

    localparam int CPB    = 8;
    localparam int MAXW   = 200;
    localparam int AW     = 8;
    localparam int PERIOD = 10;
    localparam int BV_LAT = 79 * PERIOD;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          rx = 1'b1;
    logic          restart = 1'b0;
    logic          mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    inst_loader #(.CLK_PER_BIT(CPB), .MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rx        (rx),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #(PERIOD / 2) CLK = ~CLK;

    int              compared = 0;
    int              mismatched = 0;
    int              wr_count = 0;
    logic [AW+31:0]  exp_q[$];
    logic [7:0]      tx_q[$];
    time             last_we_t = 0, done_rise_t = 0, err_rise_t = 0, last_start_t = 0;
    logic            done_q = 1'b0, err_q = 1'b0;

    // Scoreboard: every write strobe pops one expected {addr, data}.
    always @(negedge CLK) begin
        if (mem_we === 1'b1) begin
            wr_count++;
            last_we_t = $time;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write addr=%0d data=%h want no write", mem_addr, mem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    mismatched++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
        if (done && !done_q) done_rise_t = $time;
        if (err && !err_q)   err_rise_t = $time;
        done_q = done;
        err_q  = err;
    end

    initial begin
        #(PERIOD * 90000);
        $display("FAIL watchdog expired compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic pulse_restart);
        rx = 1'b0;
        last_start_t = $time;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = stop_bit;
        if (pulse_restart) begin
            // Lands on the cycle byte_valid is high for this byte.
            repeat (CPB - 2) @(negedge CLK);
            restart = 1'b1;
            @(negedge CLK);
            restart = 1'b0;
            @(negedge CLK);
        end else begin
            repeat (CPB) @(negedge CLK);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
    endtask

    task automatic send_image();
        logic [7:0] csum;
        csum = 8'h00;
        foreach (tx_q[i]) begin
            csum ^= tx_q[i];
            send_byte(tx_q[i], 1'b1, 1'b0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 1'b1, 1'b0);
`else
        if (csum == 8'hFF) ; // trailing byte only exists in the checksum build
`endif
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        compared += 3;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL restart_busy got=%b want=1", busy); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL restart_done got=%b want=0", done); end
        if (err !== 1'b0)  begin mismatched++; $display("FAIL restart_err got=%b want=0", err); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic load_image1();
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_q.push_back({8'd0, 32'h12345678});
        exp_q.push_back({8'd1, 32'hDEADBEEF});
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        compared += 6;
        if (mem_we !== 1'b0)     begin mismatched++; $display("FAIL reset_we got=%b want=0", mem_we); end
        if (mem_addr !== '0)     begin mismatched++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
        if (mem_wdata !== '0)    begin mismatched++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        if (done !== 1'b0)       begin mismatched++; $display("FAIL reset_done got=%b want=0", done); end
        if (err !== 1'b0)        begin mismatched++; $display("FAIL reset_err got=%b want=0", err); end
        if (busy !== 1'b1)       begin mismatched++; $display("FAIL reset_busy got=%b want=1", busy); end
        RST_N = 1'b1;
        repeat (4 * CPB) @(negedge CLK);
    endtask

    task automatic test_two_words();
        int wr0;
        wr0 = wr_count;
        load_image1();
        send_image();
        compared += 7;
        if (exp_q.size() != 0)       begin mismatched++; $display("FAIL two_words_pending got=%0d want=0", exp_q.size()); end
        if (wr_count - wr0 != 2)     begin mismatched++; $display("FAIL two_words_count got=%0d want=2", wr_count - wr0); end
        if (done !== 1'b1)           begin mismatched++; $display("FAIL two_words_done got=%b want=1", done); end
        if (err !== 1'b0)            begin mismatched++; $display("FAIL two_words_err got=%b want=0", err); end
        if (busy !== 1'b0)           begin mismatched++; $display("FAIL two_words_busy got=%b want=0", busy); end
        if (mem_addr !== 8'd1)       begin mismatched++; $display("FAIL two_words_addr_hold got=%0d want=1", mem_addr); end
        if (mem_wdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL two_words_data_hold got=%h want=deadbeef", mem_wdata); end
`ifdef LOADER_CHECKSUM_EN
        compared++;
        if (done_rise_t != last_start_t + BV_LAT) begin
            mismatched++; $display("FAIL two_words_done_time got=%0t want=%0t", done_rise_t, last_start_t + BV_LAT);
        end
`else
        compared += 2;
        if (last_we_t != last_start_t + BV_LAT) begin
            mismatched++; $display("FAIL two_words_we_time got=%0t want=%0t", last_we_t, last_start_t + BV_LAT);
        end
        if (done_rise_t != last_we_t + PERIOD) begin
            mismatched++; $display("FAIL two_words_done_time got=%0t want=%0t", done_rise_t, last_we_t + PERIOD);
        end
`endif
    endtask

    task automatic test_zero_count();
        int wr0;
        pulse_restart();
        wr0 = wr_count;
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_image();
        compared += 4;
        if (done !== 1'b1)       begin mismatched++; $display("FAIL zero_done got=%b want=1", done); end
        if (err !== 1'b0)        begin mismatched++; $display("FAIL zero_err got=%b want=0", err); end
        if (wr_count != wr0)     begin mismatched++; $display("FAIL zero_writes got=%0d want=0", wr_count - wr0); end
        if (done_rise_t != last_start_t + BV_LAT) begin
            mismatched++; $display("FAIL zero_done_time got=%0t want=%0t", done_rise_t, last_start_t + BV_LAT);
        end
    endtask

    task automatic test_too_many();
        int wr0;
        logic [7:0] hdr[4];
        pulse_restart();
        wr0 = wr_count;
        hdr = '{8'h00, 8'h00, 8'h00, 8'hC8};
        foreach (hdr[i]) send_byte(hdr[i], 1'b1, 1'b0);
        compared += 2;
        if (err !== 1'b0)  begin mismatched++; $display("FAIL max_words_err got=%b want=0", err); end
        if (busy !== 1'b1) begin mismatched++; $display("FAIL max_words_busy got=%b want=1", busy); end
        pulse_restart();
        hdr[3] = 8'hC9;
        foreach (hdr[i]) send_byte(hdr[i], 1'b1, 1'b0);
        compared += 5;
        if (err !== 1'b1)    begin mismatched++; $display("FAIL too_many_err got=%b want=1", err); end
        if (done !== 1'b0)   begin mismatched++; $display("FAIL too_many_done got=%b want=0", done); end
        if (busy !== 1'b0)   begin mismatched++; $display("FAIL too_many_busy got=%b want=0", busy); end
        if (wr_count != wr0) begin mismatched++; $display("FAIL too_many_writes got=%0d want=0", wr_count - wr0); end
        if (err_rise_t != last_start_t + BV_LAT) begin
            mismatched++; $display("FAIL too_many_err_time got=%0t want=%0t", err_rise_t, last_start_t + BV_LAT);
        end
    endtask

    task automatic test_frame_err();
        int wr0;
        logic [7:0] pre[6];
        pulse_restart();
        wr0 = wr_count;
        pre = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34};
        foreach (pre[i]) send_byte(pre[i], 1'b1, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        compared += 2;
        if (err !== 1'b1) begin mismatched++; $display("FAIL frame_err_err got=%b want=1", err); end
        if (err_rise_t != last_start_t + BV_LAT) begin
            mismatched++; $display("FAIL frame_err_time got=%0t want=%0t", err_rise_t, last_start_t + BV_LAT);
        end
        send_byte(8'h56, 1'b1, 1'b0);
        send_byte(8'h78, 1'b1, 1'b0);
        compared += 3;
        if (err !== 1'b1)    begin mismatched++; $display("FAIL frame_err_sticky got=%b want=1", err); end
        if (done !== 1'b0)   begin mismatched++; $display("FAIL frame_err_done got=%b want=0", done); end
        if (wr_count != wr0) begin mismatched++; $display("FAIL frame_err_writes got=%0d want=0", wr_count - wr0); end
    endtask

    task automatic test_restart_mid();
        logic [7:0] pre[6];
        pulse_restart();
        pre = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34};
        foreach (pre[i]) send_byte(pre[i], 1'b1, 1'b0);
        send_byte(8'h56, 1'b1, 1'b1);
        compared += 2;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL restart_mid_busy got=%b want=1", busy); end
        if (mem_we !== 1'b0) begin mismatched++; $display("FAIL restart_mid_we got=%b want=0", mem_we); end
        load_image1();
        send_image();
        compared += 3;
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL restart_mid_pending got=%0d want=0", exp_q.size()); end
        if (done !== 1'b1)     begin mismatched++; $display("FAIL restart_mid_done got=%b want=1", done); end
        if (err !== 1'b0)      begin mismatched++; $display("FAIL restart_mid_err got=%b want=0", err); end
    endtask

    task automatic test_reset_mid_frame();
        rx = 1'b0;
        repeat (3 * CPB) @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        compared += 3;
        if (done !== 1'b0)   begin mismatched++; $display("FAIL rst_mid_done got=%b want=0", done); end
        if (busy !== 1'b1)   begin mismatched++; $display("FAIL rst_mid_busy got=%b want=1", busy); end
        if (mem_addr !== '0) begin mismatched++; $display("FAIL rst_mid_addr got=%0d want=0", mem_addr); end
        RST_N = 1'b1;
        repeat (5 * CPB) @(negedge CLK);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
        load_image1();
        send_image();
        compared += 2;
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL rst_mid_pending got=%0d want=0", exp_q.size()); end
        if (done !== 1'b1)     begin mismatched++; $display("FAIL rst_mid_done_after got=%b want=1", done); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] img[8];
        logic [7:0] csum;
        img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        csum = 8'h00;
        foreach (img[i]) csum ^= img[i];
        pulse_restart();
        exp_q.push_back({8'd0, 32'h01020304});
        foreach (img[i]) send_byte(img[i], 1'b1, 1'b0);
        send_byte(csum, 1'b1, 1'b0);
        compared += 2;
        if (done !== 1'b1) begin mismatched++; $display("FAIL csum_good_done got=%b want=1", done); end
        if (err !== 1'b0)  begin mismatched++; $display("FAIL csum_good_err got=%b want=0", err); end
        pulse_restart();
        exp_q.push_back({8'd0, 32'h01020304});
        foreach (img[i]) send_byte(img[i], 1'b1, 1'b0);
        send_byte(csum ^ 8'h01, 1'b1, 1'b0);
        compared += 3;
        if (err !== 1'b1)      begin mismatched++; $display("FAIL csum_bad_err got=%b want=1", err); end
        if (done !== 1'b0)     begin mismatched++; $display("FAIL csum_bad_done got=%b want=0", done); end
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL csum_bad_write got=%0d pending want=0", exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_too_many();
        test_frame_err();
        test_restart_mid();
        test_reset_mid_frame();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
